countdown_display: RTL and testbench
====================================

Name: countdown_display

Overview:
Multi-digit BCD down-counter with 7-segment outputs. It is the counting-down counterpart of the score digit counter: it drives the pre-game "3-2-1" and round-timer displays on the HEX digits. It loads a BCD start value and decrements once per prescaled tick, propagating borrows across digits. It pauses on request and pulses `done` when it reaches zero.

Parameters:
- DIGITS, 2: number of BCD digits/HEX displays driven (1..6).
- TICK_DIV, 50000000: clk cycles per decrement (≥2).

Ports:
- clk  in  1: system clock.
- reset  in  1: synchronous, active-high reset.
- load  in  1: load `loadVal` and go to IDLE.
- loadVal  in  4*DIGITS: BCD start value; digit 0 is bits [3:0].
- start  in  1: begin counting from IDLE.
- pause  in  1: level; holds the count while high.
- hex  out  7*DIGITS: active-low segments, one 7-bit field per digit; digit 0 is bits [6:0].
- running  out  1: high in RUN.
- done  out  1: one-cycle pulse on reaching zero.
- isZero  out  1: level; all digits are 0.

Behaviour:
- All state is in one always_ff on posedge clk. Outputs are decoded combinationally from registered state.
- Reset puts the block in:
  - state IDLE, all digits 0, prescaler 0;
  - hex fields all 7'b1000000 ("0");
  - running=0, done=0, isZero=1.
- Input priority per edge: reset > load > start > pause > tick.
- States:
  - IDLE: holds the value.
    - start with a nonzero value → RUN, prescaler cleared.
    - start with a zero value → EXPIRED, with done pulsed that same edge.
  - RUN:
    - pause → PAUSED.
    - A tick occurs when prescaler == TICK_DIV-1. The tick clears the prescaler and decrements the value.
    - Otherwise the prescaler increments.
    - If the decrement yields all zeros → EXPIRED, done=1 for exactly the following cycle.
  - PAUSED:
    - Prescaler and value are frozen.
    - pause low → RUN, resuming from the frozen prescaler count.
  - EXPIRED:
    - Holds 0; start is ignored.
    - Only load or reset leaves this state.
- load, in any state: digits ← loadVal, prescaler ← 0, state ← IDLE, done ← 0.
  - Any nibble >9 is clamped to 9.
- Latency: with start sampled at edge N, the first decrement happens at edge N+TICK_DIV. Later decrements follow every TICK_DIV edges while in RUN.
- Borrow chain:
  - Digit 0 decrements on each tick.
  - A digit at 0 that receives a borrow wraps to 9 and asserts borrowOut to the next digit.
  - The top digit never wraps, because zero detection stops counting first.
- Tick and pause in the same cycle: pause wins, with no decrement and no prescaler advance.
- Reset in the middle of RUN or PAUSED: everything returns to reset values at that edge.
- Segment encoding, active-low, for 0–9:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
- The prescaler width is $clog2(TICK_DIV).

Decomposition:
- Shared package `display_pkg`:
  - the segment constant array SEG7_LUT[10] (active-low);
  - the state enum {IDLE, RUN, PAUSED, EXPIRED};
  - a clamp_bcd function.
- One sub-module, `bcd_down_digit`:
  - inputs: clk, reset, ld, ldVal[3:0], dec, borrowIn;
  - outputs: digit[3:0], borrowOut, hex[6:0].
- The top level instantiates DIGITS copies with a generate loop and holds the FSM and prescaler.

Test Plan:
All scenarios use DIGITS=2, TICK_DIV=4.
1. Reset held 2 cycles → hex=14'b1000000_1000000, isZero=1, running=0, done=0.
2. Load 8'h12, then start → running=1; value 11 after 4 cycles; 10 after 8; done pulses 1 cycle at 48 cycles with isZero=1; state EXPIRED, where a further start has no effect.
3. Load 8'h10, then start, wait 4 cycles → value 09, so hex[6:0]=0010000 and hex[13:7]=1000000.
4. Load 8'h05, start, run 6 cycles, hold pause 10 cycles → value 04 frozen throughout; after release, next decrement to 03 comes 2 cycles later.
5. Load 8'hAF → value 99. Start with load 8'h00 → immediate EXPIRED with a single done pulse.
6. Reset asserted mid-RUN (value 07) → value 00 and running=0 next edge. Load and start in the same cycle → load wins: state IDLE, running=0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the HEX-display counters.
//   state_e   : countdown FSM states
//   SEG7_LUT  : active-low 7-segment patterns for BCD 0..9 (bit 6 = segment g)
//   clamp_bcd : forces a non-BCD nibble (>9) to 9
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } state_e;

  localparam logic [6:0] SEG7_LUT [10] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a down-counter with its 7-segment decode.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (digit -> 0)
//   ld, ldVal[3:0]  : load the (clamped) value
//   dec             : global decrement enable (one tick)
//   borrowIn        : borrow from the lower digit (tie high for digit 0)
//   digit[3:0]      : current BCD value
//   borrowOut       : this digit is 0 and is being asked to decrement
//   hex[6:0]        : active-low segments
module bcd_down_digit
  import display_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ld,
  input  logic [3:0] ldVal,
  input  logic       dec,
  input  logic       borrowIn,
  output logic [3:0] digit,
  output logic       borrowOut,
  output logic [6:0] hex
);

  logic [3:0] digit_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else if (ld) begin
      digit_q <= clamp_bcd(ldVal);
    end else if (dec && borrowIn) begin
      digit_q <= (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end
  end

  assign digit     = digit_q;
  assign borrowOut = borrowIn && (digit_q == 4'd0);
  // digit_q never exceeds 9; blank the display if it somehow does.
  assign hex       = (digit_q <= 4'd9) ? SEG7_LUT[digit_q] : 7'b1111111;

endmodule

// File: rtl/countdown_display.sv
// Multi-digit BCD down-counter driving active-low 7-segment displays.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : load loadVal (nibbles clamped to 9), return to IDLE
//   loadVal    : BCD start value, digit 0 in bits [3:0]
//   start      : begin counting from IDLE
//   pause      : level, freezes value and prescaler while high
//   hex        : 7 segments per digit, digit 0 in bits [6:0]
//   running    : high in RUN
//   done       : one-cycle pulse after the count reaches zero
//   isZero     : all digits are zero
module countdown_display
  import display_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   loadVal,
  input  logic                  start,
  input  logic                  pause,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  running,
  output logic                  done,
  output logic                  isZero
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
  localparam logic [4*DIGITS-1:0] VALUE_ONE = 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            done_q, done_d;
  logic            tick, ld;
  logic            is_one;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS:0]     borrow;
  logic                unused_top_borrow;

  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_down_digit u_digit (
      .clk      (clk),
      .reset    (reset),
      .ld       (ld),
      .ldVal    (loadVal[4*i +: 4]),
      .dec      (tick),
      .borrowIn (borrow[i]),
      .digit    (value[4*i +: 4]),
      .borrowOut(borrow[i+1]),
      .hex      (hex[7*i +: 7])
    );
  end

  // Zero detection halts counting before the top digit could wrap.
  assign unused_top_borrow = borrow[DIGITS];

  assign isZero = (value == '0);
  assign is_one = (value == VALUE_ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    tick    = 1'b0;
    ld      = 1'b0;
    if (load) begin
      ld      = 1'b1;
      state_d = IDLE;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (isZero) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
              presc_d = '0;
            end
          end
        end
        // Releasing pause counts on the same edge, continuing the frozen prescaler.
        RUN, PAUSED: begin
          if (pause) begin
            state_d = PAUSED;
          end else begin
            state_d = RUN;
            if (presc_q == PRESC_TOP) begin
              presc_d = '0;
              tick    = 1'b1;
              if (is_one) begin
                state_d = EXPIRED;
                done_d  = 1'b1;
              end
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
        EXPIRED: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign running = (state_q == RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_display.sv
module tb_countdown_display;

  localparam int unsigned ND = 2;
  localparam int unsigned TD = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [4*ND-1:0] loadVal = '0;
  logic [7*ND-1:0] hex;
  logic            running, done, isZero;

  int errors = 0;
  int checks = 0;

  countdown_display #(.DIGITS(ND), .TICK_DIV(TD)) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .loadVal(loadVal),
    .start  (start),
    .pause  (pause),
    .hex    (hex),
    .running(running),
    .done   (done),
    .isZero (isZero)
  );

  always #5 clk = ~clk;

  logic [6:0] seg [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [13:0] hex_of(input int v);
    return {seg[(v / 10) % 10], seg[v % 10]};
  endfunction

  // Reference model: decimal value plus a count of cycles spent counting.
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_OVER = 3;
  int m_val = 0, m_phase = 0, m_mode = M_IDLE;
  bit m_done = 0;

  function automatic int clamp9(input int n);
    return (n > 9) ? 9 : n;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_val = 0; m_phase = 0; m_mode = M_IDLE; m_done = 0;
    end else if (load) begin
      m_val = 10 * clamp9(int'(loadVal[7:4])) + clamp9(int'(loadVal[3:0]));
      m_phase = 0; m_mode = M_IDLE; m_done = 0;
    end else begin
      m_done = 0;
      if (m_mode == M_IDLE) begin
        if (start) begin
          if (m_val == 0) begin m_mode = M_OVER; m_done = 1; end
          else begin m_mode = M_RUN; m_phase = 0; end
        end
      end else if (m_mode == M_RUN || m_mode == M_HOLD) begin
        if (pause) m_mode = M_HOLD;
        else begin
          m_mode = M_RUN;
          m_phase++;
          if (m_phase == TD) begin
            m_phase = 0;
            m_val--;
            if (m_val == 0) begin m_mode = M_OVER; m_done = 1; end
          end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge, model advanced with the same inputs, outputs compared afterwards.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("hex", 32'(hex), 32'(hex_of(m_val)));
    chk("running", 32'(running), 32'(m_mode == M_RUN));
    chk("done", 32'(done), 32'(m_done));
    chk("isZero", 32'(isZero), 32'(m_val == 0));
  endtask

  task automatic drive(input bit r, input bit l, input logic [7:0] lv, input bit s, input bit p);
    reset = r; load = l; loadVal = lv; start = s; pause = p;
  endtask

  typedef struct {
    string      name;
    bit         r, l, s, p;
    logic [7:0] lv;
    logic [13:0] e_hex;
    bit         e_run, e_done, e_zero;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input string nm, input bit r, input bit l, input logic [7:0] lv,
                      input bit s, input bit p, input logic [13:0] eh, input bit er,
                      input bit ed, input bit ez);
    vec_t v;
    v.name = nm; v.r = r; v.l = l; v.lv = lv; v.s = s; v.p = p;
    v.e_hex = eh; v.e_run = er; v.e_done = ed; v.e_zero = ez;
    vq.push_back(v);
  endtask

  initial begin
    // Directed vectors: one edge each, expected outputs written out by hand.
    addv("rst0",      1, 0, 8'h00, 0, 0, 14'b1000000_1000000, 0, 0, 1);
    addv("rst1",      1, 0, 8'h00, 0, 0, 14'b1000000_1000000, 0, 0, 1);
    addv("loadAF",    0, 1, 8'hAF, 0, 0, 14'b0010000_0010000, 0, 0, 0);
    addv("load00st",  0, 1, 8'h00, 1, 0, 14'b1000000_1000000, 0, 0, 1);
    addv("startzero", 0, 0, 8'h00, 1, 0, 14'b1000000_1000000, 0, 1, 1);
    addv("afterdone", 0, 0, 8'h00, 0, 0, 14'b1000000_1000000, 0, 0, 1);
    addv("expstart",  0, 0, 8'h00, 1, 0, 14'b1000000_1000000, 0, 0, 1);
    addv("load07",    0, 1, 8'h07, 0, 0, 14'b1000000_1111000, 0, 0, 0);
    addv("start07",   0, 0, 8'h00, 1, 0, 14'b1000000_1111000, 1, 0, 0);
    addv("run07",     0, 0, 8'h00, 0, 0, 14'b1000000_1111000, 1, 0, 0);
    addv("rstrun",    1, 0, 8'h00, 0, 0, 14'b1000000_1000000, 0, 0, 1);
    addv("ldst12",    0, 1, 8'h12, 1, 0, 14'b1111001_0100100, 0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].l, vq[i].lv, vq[i].s, vq[i].p);
      cyc();
      chk({vq[i].name, ".hex"}, 32'(hex), 32'(vq[i].e_hex));
      chk({vq[i].name, ".run"}, 32'(running), 32'(vq[i].e_run));
      chk({vq[i].name, ".done"}, 32'(done), 32'(vq[i].e_done));
      chk({vq[i].name, ".zero"}, 32'(isZero), 32'(vq[i].e_zero));
    end

    // Count 12 down to zero: first tick TICK_DIV edges after start.
    drive(0, 1, 8'h12, 0, 0); cyc();
    drive(0, 0, 8'h00, 1, 0); cyc();
    chk("c12.running", 32'(running), 32'd1);
    drive(0, 0, 8'h00, 0, 0);
    repeat (3) cyc();
    chk("c12.pre11", 32'(hex), 32'(14'b1111001_0100100));
    cyc();
    chk("c12.val11", 32'(hex), 32'(14'b1111001_1111001));
    repeat (4) cyc();
    chk("c12.val10", 32'(hex), 32'(14'b1111001_1000000));
    repeat (39) cyc();
    chk("c12.nodone47", 32'(done), 32'd0);
    cyc();
    chk("c12.done48", 32'(done), 32'd1);
    chk("c12.zero48", 32'(isZero), 32'd1);
    cyc();
    chk("c12.donegone", 32'(done), 32'd0);
    drive(0, 0, 8'h00, 1, 0); cyc();
    chk("c12.expstart", 32'(running), 32'd0);
    drive(0, 0, 8'h00, 0, 0); repeat (5) cyc();
    chk("c12.stillzero", 32'(hex), 32'(14'b1000000_1000000));

    // Borrow across digits: 10 -> 09.
    drive(0, 1, 8'h10, 0, 0); cyc();
    drive(0, 0, 8'h00, 1, 0); cyc();
    drive(0, 0, 8'h00, 0, 0); repeat (4) cyc();
    chk("b10.d0", 32'(hex[6:0]), 32'(7'b0010000));
    chk("b10.d1", 32'(hex[13:7]), 32'(7'b1000000));

    // Pause freezes value and prescaler; release resumes mid-period.
    drive(0, 1, 8'h05, 0, 0); cyc();
    drive(0, 0, 8'h00, 1, 0); cyc();
    drive(0, 0, 8'h00, 0, 0); repeat (6) cyc();
    chk("p05.val04", 32'(hex), 32'(14'b1000000_0011001));
    drive(0, 0, 8'h00, 0, 1);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("p05.frozen", 32'(hex), 32'(14'b1000000_0011001));
      chk("p05.notrun", 32'(running), 32'd0);
    end
    drive(0, 0, 8'h00, 0, 0); cyc();
    chk("p05.rel1", 32'(hex), 32'(14'b1000000_0011001));
    chk("p05.rel1run", 32'(running), 32'd1);
    cyc();
    chk("p05.val03", 32'(hex), 32'(14'b1000000_0110000));

    // Tick and pause on the same edge: pause wins.
    drive(0, 0, 8'h00, 0, 0); repeat (3) cyc();
    drive(0, 0, 8'h00, 0, 1); cyc();
    chk("tp.noval", 32'(hex), 32'(14'b1000000_0110000));
    drive(0, 0, 8'h00, 0, 0); cyc();
    chk("tp.val02", 32'(hex), 32'(14'b1000000_0100100));

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] lv;
      lv = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) lv[7:4] = 4'd0;
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0), lv,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
